// File: rtl/sib_key_comparator.sv
// -----------------------------------------------------------------------------
// sib_key_comparator
//   Serial key check sitting directly upstream of a secure SIB in the scan path.
//   A tester-supplied key is shifted in LSB-first and compared against a
//   hard-wired key. The registered match, masked by the lockout flag, drives the
//   SIB's CompOut. Failed update attempts are counted, and the comparator locks
//   out permanently (until reset) after MAX_FAIL consecutive failures.
//
//   Optional feature macro: KEYCMP_LOCKOUT_EN
//     defined   : failure counter and sticky lockout are built.
//     undefined : no counter/lock flops; o_fail_count=0, o_locked=0,
//                 o_comp_out follows the registered match (unlimited attempts).
//
// Ports
//   i_clk        scan clock, all state on rising edge
//   i_rst        asynchronous active-high reset
//   i_si         serial scan data in
//   i_select     segment select (shared with the SIB)
//   i_shift_en   shift-DR enable
//   i_capture_en capture-DR enable
//   i_update_en  update-DR enable
//   o_so         serial out, key_sr[0], feeds the SIB's SI
//   o_comp_out   key-match flag to the SIB
//   o_locked     sticky lockout flag
//   o_fail_count consecutive failed update count (saturating)
// -----------------------------------------------------------------------------
module sib_key_comparator #(
   parameter int unsigned          KEY_W     = 16,
   parameter logic [KEY_W-1:0]     KEY_VALUE = 16'hC3A5,
   parameter int unsigned          MAX_FAIL  = 3,
   parameter int unsigned          FAIL_W    = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_si,
   input  logic              i_select,
   input  logic              i_shift_en,
   input  logic              i_capture_en,
   input  logic              i_update_en,
   output logic              o_so,
   output logic              o_comp_out,
   output logic              o_locked,
   output logic [FAIL_W-1:0] o_fail_count
);

   logic             w_sh;
   logic             w_cap;
   logic             w_upd;
   logic             w_comp_out;
   logic [KEY_W-1:0] r_key_sr;
   logic             r_match;

   assign w_sh  = i_select & i_shift_en;
   assign w_cap = i_select & i_capture_en;
   assign w_upd = i_select & i_update_en;

   // Update and capture both clear the key so a previously accepted key cannot
   // be replayed on a later update.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_key_sr <= '0;
         r_match  <= 1'b0;
      end else begin
         if (w_upd || w_cap) begin
            r_key_sr <= '0;
         end else if (w_sh) begin
            r_key_sr <= {i_si, r_key_sr[KEY_W-1:1]};
         end
         // Registered compare: stable through the non-shift cycle before update.
         r_match <= (r_key_sr == KEY_VALUE);
      end
   end

`ifdef KEYCMP_LOCKOUT_EN
   localparam logic [FAIL_W:0] LP_MAX_FAIL = (FAIL_W + 1)'(MAX_FAIL);
   localparam logic [FAIL_W:0] LP_ONE      = (FAIL_W + 1)'(1);

   logic [FAIL_W-1:0] r_fail_count;
   logic              r_locked;
   logic [FAIL_W:0]   w_fail_inc;
   logic              w_fail_hit;

   // One extra bit so the increment can never wrap before saturation.
   assign w_fail_inc = {1'b0, r_fail_count} + LP_ONE;
   assign w_fail_hit = (w_fail_inc >= LP_MAX_FAIL);
   assign w_comp_out = r_match & ~r_locked;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fail_count <= '0;
         r_locked     <= 1'b0;
      end else if (w_upd) begin
         if (w_comp_out) begin
            r_fail_count <= '0;
         end else if (w_fail_hit) begin
            r_fail_count <= LP_MAX_FAIL[FAIL_W-1:0];
            r_locked     <= 1'b1;
         end else begin
            r_fail_count <= w_fail_inc[FAIL_W-1:0];
         end
      end
   end

   assign o_fail_count = r_fail_count;
   assign o_locked     = r_locked;
`else
   assign w_comp_out   = r_match;
   assign o_fail_count = '0;
   assign o_locked     = 1'b0;
`endif

   assign o_so       = r_key_sr[0];
   assign o_comp_out = w_comp_out;

endmodule
